// File: rtl/pic_cmd_if.sv
// CPU bus pins seen by the PIC command sequencer.
interface pic_cmd_if;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       a0;
    logic [7:0] din;

    modport master (output cs_n, output wr_n, output rd_n, output a0, output din);
    modport slave  (input  cs_n, input  wr_n, input  rd_n, input  a0, input  din);
endinterface

// File: rtl/pic_cmd_sequencer.sv
// 8259A-style command sequencer: bus write capture/commit, ICW init FSM, OCW routing.
module pic_cmd_sequencer #(
    parameter int unsigned VECTOR_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    pic_cmd_if.slave            bus,
    output logic [1:0]          icw_to_be_sent,
    output logic                init_done,
    output logic                ltim,
    output logic                sngl,
    output logic                ic4,
    output logic [VECTOR_W-1:0] vector_base,
    output logic [7:0]          icw3_reg,
    output logic                aeoi,
    output logic                upm,
    output logic [7:0]          imr,
    output logic                ocw2_valid,
    output logic [7:0]          ocw2_cmd,
    output logic                poll_pulse,
    output logic                read_isr,
    output logic                special_mask,
    output logic [1:0]          rd_sel,
    output logic                cmd_error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_W_ICW2 = 3'd1;
    localparam logic [2:0] S_W_ICW3 = 3'd2;
    localparam logic [2:0] S_W_ICW4 = 3'd3;
    localparam logic [2:0] S_READY  = 3'd4;

    logic [2:0]          state, state_nx;
    logic                wr_q, wr_sel, wr_sel_nx;
    logic                a0_q, a0_q_nx;
    logic [7:0]          din_q, din_q_nx;
    logic                commit, is_icw1;

    logic [1:0]          icw_to_be_sent_nx;
    logic                init_done_nx, ltim_nx, sngl_nx, ic4_nx;
    logic [VECTOR_W-1:0] vector_base_nx;
    logic [7:0]          icw3_reg_nx, imr_nx, ocw2_cmd_nx;
    logic                aeoi_nx, upm_nx, ocw2_valid_nx, poll_pulse_nx;
    logic                read_isr_nx, special_mask_nx, cmd_error_nx;

    // Write commits on the first edge that sees the strobe high again after a captured low phase.
    assign commit  = !wr_q && bus.wr_n && wr_sel;
    assign is_icw1 = !a0_q && din_q[4];

    // Read mux select straight from the bus pins; IMR is only readable once initialized.
    always_comb begin
        rd_sel = 2'b00;
        if (!bus.cs_n && !bus.rd_n) begin
            if (!bus.a0)
                rd_sel = 2'b01;
            else if (init_done)
                rd_sel = 2'b10;
        end
    end

    // Next-state, capture and configuration-register decode.
    always_comb begin
        state_nx        = state;
        wr_sel_nx       = wr_sel;
        a0_q_nx         = a0_q;
        din_q_nx        = din_q;
        ltim_nx         = ltim;
        sngl_nx         = sngl;
        ic4_nx          = ic4;
        vector_base_nx  = vector_base;
        icw3_reg_nx     = icw3_reg;
        aeoi_nx         = aeoi;
        upm_nx          = upm;
        imr_nx          = imr;
        ocw2_cmd_nx     = ocw2_cmd;
        read_isr_nx     = read_isr;
        special_mask_nx = special_mask;
        ocw2_valid_nx   = 1'b0;
        poll_pulse_nx   = 1'b0;
        cmd_error_nx    = 1'b0;

        if (!bus.cs_n && !bus.wr_n) begin
            wr_sel_nx = 1'b1;
            a0_q_nx   = bus.a0;
            din_q_nx  = bus.din;
        end

        if (commit) begin
            wr_sel_nx = 1'b0;
            if (is_icw1) begin
                ltim_nx         = din_q[3];
                sngl_nx         = din_q[1];
                ic4_nx          = din_q[0];
                imr_nx          = 8'h00;
                special_mask_nx = 1'b0;
                read_isr_nx     = 1'b0;
                aeoi_nx         = 1'b0;
                upm_nx          = 1'b0;
                icw3_reg_nx     = 8'h00;
                state_nx        = S_W_ICW2;
            end else begin
                case (state)
                    S_W_ICW2: begin
                        if (a0_q) begin
                            vector_base_nx = VECTOR_W'(din_q[7:3]);
                            if (!sngl)
                                state_nx = S_W_ICW3;
                            else if (ic4)
                                state_nx = S_W_ICW4;
                            else
                                state_nx = S_READY;
                        end else begin
                            cmd_error_nx = 1'b1;
                        end
                    end
                    S_W_ICW3: begin
                        if (a0_q) begin
                            icw3_reg_nx = din_q;
                            state_nx    = ic4 ? S_W_ICW4 : S_READY;
                        end else begin
                            cmd_error_nx = 1'b1;
                        end
                    end
                    S_W_ICW4: begin
                        if (a0_q && din_q[7:5] == 3'b000) begin
                            aeoi_nx  = din_q[1];
                            upm_nx   = din_q[0];
                            state_nx = S_READY;
                        end else begin
                            cmd_error_nx = 1'b1;
                        end
                    end
                    S_READY: begin
                        if (a0_q) begin
                            imr_nx = din_q;
                        end else if (!din_q[3]) begin
                            ocw2_valid_nx = 1'b1;
                            ocw2_cmd_nx   = din_q;
                        end else if (!din_q[7]) begin
                            if (din_q[1])
                                read_isr_nx = din_q[0];
                            if (din_q[6])
                                special_mask_nx = din_q[5];
                            poll_pulse_nx = din_q[2];
                        end else begin
                            cmd_error_nx = 1'b1;
                        end
                    end
                    default: cmd_error_nx = 1'b1;
                endcase
            end
        end

        icw_to_be_sent_nx = 2'b00;
        init_done_nx      = 1'b0;
        case (state_nx)
            S_W_ICW2: icw_to_be_sent_nx = 2'b01;
            S_W_ICW3: icw_to_be_sent_nx = 2'b10;
            S_W_ICW4: icw_to_be_sent_nx = 2'b11;
            S_READY:  init_done_nx      = 1'b1;
            default:  icw_to_be_sent_nx = 2'b00;
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            wr_q           <= 1'b1;
            wr_sel         <= 1'b0;
            a0_q           <= 1'b0;
            din_q          <= 8'h00;
            icw_to_be_sent <= 2'b00;
            init_done      <= 1'b0;
            ltim           <= 1'b0;
            sngl           <= 1'b0;
            ic4            <= 1'b0;
            vector_base    <= '0;
            icw3_reg       <= 8'h00;
            aeoi           <= 1'b0;
            upm            <= 1'b0;
            imr            <= 8'hff;
            ocw2_valid     <= 1'b0;
            ocw2_cmd       <= 8'h00;
            poll_pulse     <= 1'b0;
            read_isr       <= 1'b0;
            special_mask   <= 1'b0;
            cmd_error      <= 1'b0;
        end else begin
            state          <= state_nx;
            wr_q           <= bus.wr_n;
            wr_sel         <= wr_sel_nx;
            a0_q           <= a0_q_nx;
            din_q          <= din_q_nx;
            icw_to_be_sent <= icw_to_be_sent_nx;
            init_done      <= init_done_nx;
            ltim           <= ltim_nx;
            sngl           <= sngl_nx;
            ic4            <= ic4_nx;
            vector_base    <= vector_base_nx;
            icw3_reg       <= icw3_reg_nx;
            aeoi           <= aeoi_nx;
            upm            <= upm_nx;
            imr            <= imr_nx;
            ocw2_valid     <= ocw2_valid_nx;
            ocw2_cmd       <= ocw2_cmd_nx;
            poll_pulse     <= poll_pulse_nx;
            read_isr       <= read_isr_nx;
            special_mask   <= special_mask_nx;
            cmd_error      <= cmd_error_nx;
        end
    end

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Directed bench for pic_cmd_sequencer: init sequences, OCW traffic, errors, reset and read select.
module tb_pic_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic [1:0] icw_to_be_sent;
    logic       init_done, ltim, sngl, ic4;
    logic [4:0] vector_base;
    logic [7:0] icw3_reg;
    logic       aeoi, upm;
    logic [7:0] imr;
    logic       ocw2_valid;
    logic [7:0] ocw2_cmd;
    logic       poll_pulse, read_isr, special_mask;
    logic [1:0] rd_sel;
    logic       cmd_error;

    int checks = 0;
    int errors = 0;

    pic_cmd_if bus ();

    pic_cmd_sequencer #(.VECTOR_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .icw_to_be_sent (icw_to_be_sent),
        .init_done      (init_done),
        .ltim           (ltim),
        .sngl           (sngl),
        .ic4            (ic4),
        .vector_base    (vector_base),
        .icw3_reg       (icw3_reg),
        .aeoi           (aeoi),
        .upm            (upm),
        .imr            (imr),
        .ocw2_valid     (ocw2_valid),
        .ocw2_cmd       (ocw2_cmd),
        .poll_pulse     (poll_pulse),
        .read_isr       (read_isr),
        .special_mask   (special_mask),
        .rd_sel         (rd_sel),
        .cmd_error      (cmd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-clock write; returns 1ns after the commit edge.
    task automatic bus_write(input logic a, input logic [7:0] d);
        @(negedge clk);
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = a; bus.din = d;
        @(negedge clk);
        bus.cs_n = 1'b1; bus.wr_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cs_n = 1'b1; bus.wr_n = 1'b1; bus.rd_n = 1'b1; bus.a0 = 1'b0; bus.din = 8'h00;
        #12;
        checks++; if (icw_to_be_sent !== 2'b00) begin errors++; $display("FAIL reset_icw got %b exp 00", icw_to_be_sent); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b exp 0", init_done); end
        checks++; if (imr !== 8'hff) begin errors++; $display("FAIL reset_imr got %h exp ff", imr); end
        checks++; if (vector_base !== 5'd0 || icw3_reg !== 8'h00) begin errors++; $display("FAIL reset_cfg got vb=%h icw3=%h exp 0/00", vector_base, icw3_reg); end
        checks++; if ({ocw2_valid, poll_pulse, cmd_error, read_isr, special_mask, aeoi, upm} !== 7'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000000", {ocw2_valid, poll_pulse, cmd_error, read_isr, special_mask, aeoi, upm}); end
        checks++; if (ocw2_cmd !== 8'h00) begin errors++; $display("FAIL reset_ocw2_cmd got %h exp 00", ocw2_cmd); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_error();
        bus_write(1'b0, 8'h00);
        checks++; if (cmd_error !== 1'b1) begin errors++; $display("FAIL idle_err got %b exp 1", cmd_error); end
        checks++; if (icw_to_be_sent !== 2'b00) begin errors++; $display("FAIL idle_err_state got %b exp 00", icw_to_be_sent); end
        next_cycle();
        checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL idle_err_width got %b exp 0", cmd_error); end
        @(negedge clk);
        bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.a0 = 1'b1;
        #1;
        checks++; if (rd_sel !== 2'b00) begin errors++; $display("FAIL rd_sel_preinit got %b exp 00", rd_sel); end
        @(negedge clk);
        bus.cs_n = 1'b1; bus.rd_n = 1'b1;
        next_cycle();
        checks++; if (icw_to_be_sent !== 2'b00 || init_done !== 1'b0) begin errors++; $display("FAIL rd_preinit_state got %b/%b exp 00/0", icw_to_be_sent, init_done); end
    endtask

    task automatic test_full_init();
        bus_write(1'b0, 8'h11);
        checks++; if (icw_to_be_sent !== 2'b01) begin errors++; $display("FAIL init_icw1 got %b exp 01", icw_to_be_sent); end
        checks++; if (imr !== 8'h00) begin errors++; $display("FAIL init_imr got %h exp 00", imr); end
        checks++; if ({ltim, sngl, ic4} !== 3'b001) begin errors++; $display("FAIL init_icw1_bits got %b exp 001", {ltim, sngl, ic4}); end
        bus_write(1'b1, 8'h48);
        checks++; if (icw_to_be_sent !== 2'b10) begin errors++; $display("FAIL init_icw2 got %b exp 10", icw_to_be_sent); end
        checks++; if (vector_base !== 5'h09) begin errors++; $display("FAIL init_vb got %h exp 09", vector_base); end
        bus_write(1'b1, 8'h04);
        checks++; if (icw_to_be_sent !== 2'b11) begin errors++; $display("FAIL init_icw3 got %b exp 11", icw_to_be_sent); end
        checks++; if (icw3_reg !== 8'h04) begin errors++; $display("FAIL init_icw3_reg got %h exp 04", icw3_reg); end
        bus_write(1'b1, 8'h01);
        checks++; if (icw_to_be_sent !== 2'b00 || init_done !== 1'b1) begin errors++; $display("FAIL init_done got %b/%b exp 00/1", icw_to_be_sent, init_done); end
        checks++; if (upm !== 1'b1 || aeoi !== 1'b0) begin errors++; $display("FAIL init_icw4 got upm=%b aeoi=%b exp 1/0", upm, aeoi); end
    endtask

    task automatic test_read_sel();
        @(negedge clk);
        bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.a0 = 1'b1;
        #1;
        checks++; if (rd_sel !== 2'b10) begin errors++; $display("FAIL rd_sel_imr got %b exp 10", rd_sel); end
        bus.a0 = 1'b0;
        #1;
        checks++; if (rd_sel !== 2'b01) begin errors++; $display("FAIL rd_sel_irr got %b exp 01", rd_sel); end
        bus.cs_n = 1'b1;
        #1;
        checks++; if (rd_sel !== 2'b00) begin errors++; $display("FAIL rd_sel_nocs got %b exp 00", rd_sel); end
        @(negedge clk);
        bus.rd_n = 1'b1;
        next_cycle();
        checks++; if (init_done !== 1'b1 || imr !== 8'h00) begin errors++; $display("FAIL rd_no_change got %b/%h exp 1/00", init_done, imr); end
    endtask

    task automatic test_ocw();
        bus_write(1'b1, 8'hA5);
        checks++; if (imr !== 8'hA5) begin errors++; $display("FAIL ocw1_imr got %h exp a5", imr); end
        bus_write(1'b0, 8'h20);
        checks++; if (ocw2_valid !== 1'b1 || ocw2_cmd !== 8'h20) begin errors++; $display("FAIL ocw2 got v=%b cmd=%h exp 1/20", ocw2_valid, ocw2_cmd); end
        next_cycle();
        checks++; if (ocw2_valid !== 1'b0) begin errors++; $display("FAIL ocw2_width got %b exp 0", ocw2_valid); end
        bus_write(1'b0, 8'h0B);
        checks++; if (read_isr !== 1'b1 || poll_pulse !== 1'b0 || ocw2_valid !== 1'b0) begin errors++; $display("FAIL ocw3_risr got %b/%b/%b exp 1/0/0", read_isr, poll_pulse, ocw2_valid); end
        bus_write(1'b0, 8'h6C);
        checks++; if (special_mask !== 1'b1 || poll_pulse !== 1'b1 || read_isr !== 1'b1) begin errors++; $display("FAIL ocw3_smm got smm=%b poll=%b risr=%b exp 1/1/1", special_mask, poll_pulse, read_isr); end
        next_cycle();
        checks++; if (poll_pulse !== 1'b0) begin errors++; $display("FAIL poll_width got %b exp 0", poll_pulse); end
        bus_write(1'b0, 8'h88);
        checks++; if (cmd_error !== 1'b1 || read_isr !== 1'b1 || special_mask !== 1'b1) begin errors++; $display("FAIL ocw3_d7_err got %b/%b/%b exp 1/1/1", cmd_error, read_isr, special_mask); end
    endtask

    task automatic test_back_to_back();
        // Strobe low for two clocks with changing data, then chip select released before the strobe.
        @(negedge clk);
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = 1'b1; bus.din = 8'h11;
        @(negedge clk);
        bus.din = 8'h3C;
        @(negedge clk);
        bus.cs_n = 1'b1; bus.din = 8'hEE;
        @(negedge clk);
        bus.wr_n = 1'b1;
        next_cycle();
        checks++; if (imr !== 8'h3C) begin errors++; $display("FAIL last_byte_cs_early got %h exp 3c", imr); end
        bus_write(1'b1, 8'h5A);
        checks++; if (imr !== 8'h5A) begin errors++; $display("FAIL b2b_first got %h exp 5a", imr); end
        bus_write(1'b1, 8'hC3);
        checks++; if (imr !== 8'hC3) begin errors++; $display("FAIL b2b_second got %h exp c3", imr); end
    endtask

    task automatic test_single();
        bus_write(1'b0, 8'h12);
        checks++; if (icw_to_be_sent !== 2'b01 || init_done !== 1'b0) begin errors++; $display("FAIL single_icw1 got %b/%b exp 01/0", icw_to_be_sent, init_done); end
        checks++; if (read_isr !== 1'b0 || special_mask !== 1'b0 || upm !== 1'b0 || imr !== 8'h00) begin errors++; $display("FAIL single_clear got %b/%b/%b/%h exp 0/0/0/00", read_isr, special_mask, upm, imr); end
        bus_write(1'b1, 8'h20);
        checks++; if (init_done !== 1'b1 || icw_to_be_sent !== 2'b00) begin errors++; $display("FAIL single_ready got %b/%b exp 1/00", init_done, icw_to_be_sent); end
        checks++; if (vector_base !== 5'h04 || aeoi !== 1'b0 || upm !== 1'b0 || sngl !== 1'b1) begin errors++; $display("FAIL single_cfg got %h/%b/%b/%b exp 04/0/0/1", vector_base, aeoi, upm, sngl); end
    endtask

    task automatic test_illegal();
        bus_write(1'b0, 8'h11);
        bus_write(1'b1, 8'h48);
        bus_write(1'b1, 8'h04);
        bus_write(1'b1, 8'hE1);
        checks++; if (cmd_error !== 1'b1 || icw_to_be_sent !== 2'b11 || upm !== 1'b0) begin errors++; $display("FAIL icw4_bad got err=%b icw=%b upm=%b exp 1/11/0", cmd_error, icw_to_be_sent, upm); end
        next_cycle();
        checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL icw4_bad_width got %b exp 0", cmd_error); end
        bus_write(1'b0, 8'h00);
        checks++; if (cmd_error !== 1'b1 || icw_to_be_sent !== 2'b11) begin errors++; $display("FAIL init_a0_err got %b/%b exp 1/11", cmd_error, icw_to_be_sent); end
    endtask

    task automatic test_reset_mid();
        bus_write(1'b1, 8'h02);
        checks++; if (init_done !== 1'b1 || aeoi !== 1'b1) begin errors++; $display("FAIL icw4_aeoi got %b/%b exp 1/1", init_done, aeoi); end
        bus_write(1'b1, 8'h33);
        bus_write(1'b0, 8'h11);
        bus_write(1'b1, 8'h48);
        bus_write(1'b1, 8'h04);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (imr !== 8'hff || init_done !== 1'b0 || icw_to_be_sent !== 2'b00) begin errors++; $display("FAIL async_reset got imr=%h done=%b icw=%b exp ff/0/00", imr, init_done, icw_to_be_sent); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_restart();
        bus_write(1'b0, 8'h11);
        bus_write(1'b1, 8'h48);
        checks++; if (icw_to_be_sent !== 2'b10) begin errors++; $display("FAIL restart_pre got %b exp 10", icw_to_be_sent); end
        bus_write(1'b0, 8'h13);
        checks++; if (icw_to_be_sent !== 2'b01 || imr !== 8'h00 || sngl !== 1'b1) begin errors++; $display("FAIL restart got icw=%b imr=%h sngl=%b exp 01/00/1", icw_to_be_sent, imr, sngl); end
        bus_write(1'b1, 8'h50);
        checks++; if (icw_to_be_sent !== 2'b11 || vector_base !== 5'h0A) begin errors++; $display("FAIL restart_icw2 got %b/%h exp 11/0a", icw_to_be_sent, vector_base); end
    endtask

    initial begin
        test_reset();
        test_idle_error();
        test_full_init();
        test_read_sel();
        test_ocw();
        test_back_to_back();
        test_single();
        test_illegal();
        test_reset_mid();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
